// File: rtl/lcd_write_arbiter.sv
// Two-requester round-robin arbiter driving a 4-bit HD44780-style LCD write (two nibble strobes, then settle wait).
// gnt is a same-cycle accept in IDLE only; requests seen while busy stay pending until the FSM returns to IDLE.
module lcd_write_arbiter #(
  parameter int T_SETUP    = 2,
  parameter int T_EN       = 12,
  parameter int T_GAP      = 50,
  parameter int T_WAIT     = 2000,
  parameter int T_CLR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done,
  output logic       busy,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  localparam int MAX_WAIT  = (T_WAIT > T_CLR_WAIT) ? T_WAIT : T_CLR_WAIT;
  localparam int MAX_STRB  = (T_EN > T_SETUP) ? T_EN : T_SETUP;
  localparam int MAX_SHORT = (T_GAP > MAX_STRB) ? T_GAP : MAX_STRB;
  localparam int MAX_T     = (MAX_WAIT > MAX_SHORT) ? MAX_WAIT : MAX_SHORT;
  localparam int CNT_W     = ($clog2(MAX_T + 1) > 17) ? $clog2(MAX_T + 1) : 17;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE,
    HI_SETUP,
    HI_EN,
    HI_HOLD,
    GAP,
    LO_SETUP,
    LO_EN,
    LO_HOLD,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             pick1;
  logic             last;
  logic             is_clr;

  // ptr_q=1 gives requester 1 priority on a tie; a lone request always wins.
  assign pick1  = req1 & (~req0 | ptr_q);
  assign last   = (cnt_q == '0);
  assign is_clr = ~rs_q & (data_q == 8'h01);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rs_d    = rs_q;
    data_d  = data_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done    = 1'b0;

    if (state_q != IDLE && !last) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        // gnt is combinational from req, so it must be masked while reset is held.
        if (reset && (req0 || req1)) begin
          gnt0    = ~pick1;
          gnt1    = pick1;
          rs_d    = pick1 ? rs1 : rs0;
          data_d  = pick1 ? data1 : data0;
          ptr_d   = ~pick1;
          state_d = HI_SETUP;
          cnt_d   = LD_SETUP;
        end
      end
      HI_SETUP: if (last) begin state_d = HI_EN;    cnt_d = LD_EN;    end
      HI_EN:    if (last) begin state_d = HI_HOLD;  cnt_d = '0;       end
      HI_HOLD:  if (last) begin state_d = GAP;      cnt_d = LD_GAP;   end
      GAP:      if (last) begin state_d = LO_SETUP; cnt_d = LD_SETUP; end
      LO_SETUP: if (last) begin state_d = LO_EN;    cnt_d = LD_EN;    end
      LO_EN:    if (last) begin state_d = LO_HOLD;  cnt_d = '0;       end
      LO_HOLD: begin
        if (last) begin
          state_d = WAIT;
          cnt_d   = is_clr ? LD_CLR : LD_WAIT;
        end
      end
      WAIT: begin
        done = last;
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode state_q only, so an async reset drops them within the same cycle.
  always_comb begin
    busy   = (state_q != IDLE);
    LCD_E  = (state_q == HI_EN) || (state_q == LO_EN);
    LCD_RW = 1'b0;
    LCD_RS = 1'b0;
    SF_D   = 4'h0;
    case (state_q)
      HI_SETUP, HI_EN, HI_HOLD: begin
        SF_D   = data_q[7:4];
        LCD_RS = rs_q;
      end
      GAP: LCD_RS = rs_q;
      LO_SETUP, LO_EN, LO_HOLD: begin
        SF_D   = data_q[3:0];
        LCD_RS = rs_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: grant vector table, per-cycle strobe timeline, done scoreboard, and
// hand-written sequences for contention, busy blocking, the clear wait, reset abort and idle outputs.
module tb_lcd_write_arbiter;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       req0  = 1'b0;
  logic       req1  = 1'b0;
  logic       rs0   = 1'b0;
  logic       rs1   = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       gnt0, gnt1, done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] sf_d;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int due;
  } sb_t;
  sb_t sb_q[$];
  int  gnt_id_q[$];
  int  gnt_cyc_q[$];

  typedef struct {
    logic       r0, r1, s0, s1;
    logic [7:0] d0, d1;
    logic       g0, g1;
    logic [3:0] sfd;
    logic       rs;
    logic       bsy;
  } vec_t;
  vec_t vt[5];

  lcd_write_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .rs0    (rs0),
    .rs1    (rs1),
    .data0  (data0),
    .data1  (data1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done   (done),
    .busy   (busy),
    .SF_D   (sf_d),
    .LCD_E  (lcd_e),
    .LCD_RS (lcd_rs),
    .LCD_RW (lcd_rw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each grant pushes the cycle its done must land on; each done pops in order.
  always @(negedge clk) begin
    sb_t        e;
    logic       g_rs;
    logic [7:0] g_dat;
    if (!reset) begin
      sb_q.delete();
    end else begin
      if (gnt0 || gnt1) begin
        check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        check("gnt_while_busy", 32'(busy), 32'd0);
        g_rs  = gnt1 ? rs1 : rs0;
        g_dat = gnt1 ? data1 : data0;
        e.id  = gnt1 ? 1 : 0;
        e.due = cyc + ((!g_rs && g_dat == 8'h01) ? 82080 : 2080);
        sb_q.push_back(e);
        gnt_id_q.push_back(e.id);
        gnt_cyc_q.push_back(cyc);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic wait_gnt(input int max_cyc, output int t);
    t = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        t = cyc;
        break;
      end
    end
    check("gnt_seen", 32'(t >= 0), 32'd1);
  endtask

  // Walks cycles gnt+1..gnt+len against the expected strobe timeline with default timings.
  task automatic wave_check(input string tag, input logic [7:0] b, input logic r, input int len);
    int         mis, ehi, first_k, w;
    logic [8:0] got, want, first_got, first_want;
    logic       e, hi, lo;
    logic [3:0] sd;
    mis = 0; ehi = 0; first_k = -1; first_got = '0; first_want = '0;
    w = (!r && b == 8'h01) ? 82000 : 2000;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      hi   = (k <= 15);
      lo   = (k >= 66 && k <= 80);
      e    = (k >= 3 && k <= 14) || (k >= 68 && k <= 79);
      sd   = hi ? b[7:4] : (lo ? b[3:0] : 4'h0);
      want = {1'b0, (k <= 80 + w), (k == 80 + w), ((k <= 80) ? r : 1'b0), e, sd};
      got  = {lcd_rw, busy, done, lcd_rs, lcd_e, sf_d};
      if (lcd_e) ehi++;
      if (got !== want) begin
        mis++;
        if (first_k < 0) begin
          first_k = k; first_got = got; first_want = want;
        end
      end
    end
    checks++;
    if (mis != 0) begin
      failures++;
      $display("FAIL wave_%s: %0d bad cycles, first at gnt+%0d {rw,busy,done,rs,e,sfd} actual=%h required=%h",
               tag, mis, first_k, first_got, first_want);
    end
    check({"e_high_cycles_", tag}, 32'(ehi), 32'd24);
  endtask

  initial begin
    int t, t2, bad, dcnt, n;

    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h7E, 8'hC3, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h0F, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1};

    // Outputs while reset is held, with both requests pending.
    req0 = 1'b1; req1 = 1'b1; rs0 = 1'b1; rs1 = 1'b1; data0 = 8'hFF; data1 = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lcd_e", 32'(lcd_e), 32'd0);
    check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    check("rst_sf_d", 32'(sf_d), 32'd0);

    // Each vector starts from reset, so the priority pointer is at requester 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      req0 = vt[i].r0; req1 = vt[i].r1; rs0 = vt[i].s0; rs1 = vt[i].s1;
      data0 = vt[i].d0; data1 = vt[i].d1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(vt[i].g0));
      check($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(vt[i].g1));
      @(negedge clk);
      check($sformatf("vec%0d_sf_d", i), 32'(sf_d), 32'(vt[i].sfd));
      check($sformatf("vec%0d_rs", i), 32'(lcd_rs), 32'(vt[i].rs));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      check($sformatf("vec%0d_e_setup", i), 32'(lcd_e), 32'd0);
    end

    // Reset abort during LO_EN.
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b1; rs0 = 1'b1; data0 = 8'hA7;
    wait_gnt(1, t);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (68) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_pre_e", 32'(lcd_e), 32'd1);
    check("abort_pre_sf_d", 32'(sf_d), 32'h7);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_lcd_e", 32'(lcd_e), 32'd0);
    check("abort_sf_d", 32'(sf_d), 32'd0);
    check("abort_rs", 32'(lcd_rs), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Idle outputs for 5000 cycles; also covers the abandoned byte never completing.
    bad = 0; dcnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sf_d != 4'h0 || lcd_e || lcd_rw || busy) bad++;
      if (done || lcd_e) dcnt++;
    end
    check("idle_outputs_bad_cycles", 32'(bad), 32'd0);
    check("abort_no_done_or_strobe", 32'(dcnt), 32'd0);

    // Contention from reset release; the first byte also exercises the full strobe timeline.
    @(posedge clk); #1;
    reset = 1'b0;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h48;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h35;
    gnt_id_q.delete();
    gnt_cyc_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    wait_gnt(1, t);
    check("cont_first_is_gnt0", 32'(gnt0), 32'd1);
    wave_check("single48", 8'h48, 1'b1, 2081);
    for (int i = 0; i < 4300 && gnt_id_q.size() < 4; i++) @(negedge clk);
    n = gnt_id_q.size();
    check("cont_grant_count", 32'(n), 32'd4);
    if (n >= 4) begin
      check("cont_order0", 32'(gnt_id_q[0]), 32'd0);
      check("cont_order1", 32'(gnt_id_q[1]), 32'd1);
      check("cont_order2", 32'(gnt_id_q[2]), 32'd0);
      check("cont_order3", 32'(gnt_id_q[3]), 32'd1);
      for (int i = 0; i < 3; i++)
        check($sformatf("cont_spacing%0d", i), 32'(gnt_cyc_q[i+1] - gnt_cyc_q[i]), 32'd2081);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b1; rs0 = 1'b1; data0 = 8'h52;

    // Busy blocking: req1 (clear command) raised at t+500 must wait until t+2081.
    wait_gnt(1, t);
    check("blk_first_is_gnt0", 32'(gnt0), 32'd1);
    fork
      wave_check("blk52", 8'h52, 1'b1, 2081);
      begin
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (499) @(posedge clk);
        #1;
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
      end
    join
    check("blk_gnt1_at_t2081", 32'(gnt1), 32'd1);
    t2 = cyc;
    check("blk_gnt_delay", 32'(t2 - t), 32'd2081);

    // Clear command: long wait, 24 strobe cycles, done checked by the scoreboard at +82080.
    fork
      wave_check("clr01", 8'h01, 1'b0, 82081);
      begin
        @(posedge clk); #1;
        req1 = 1'b0;
      end
    join
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, cycles nibble data and RS are valid before LCD_E rises.
REQ-002 SHALL have parameter T_EN, default 12, cycles LCD_E is held high per nibble.
REQ-003 SHALL have parameter T_GAP, default 50, cycles between the upper-nibble and lower-nibble strobes (1 us at 50 MHz).
REQ-004 SHALL have parameter T_WAIT, default 2000, post-byte wait cycles (40 us).
REQ-005 SHALL have parameter T_CLR_WAIT, default 82000, post-byte wait cycles for the clear command (RS=0, byte 8'h01).
REQ-006 SHALL have the following ports:
  - clk  in  1  system clock; all state updates on its rising edge.
  - reset  in  1  asynchronous, active-low; 0 clears all state immediately.
  - req0 / req1  in  1  write request from requester 0 / 1.
  - rs0 / rs1  in  1  RS value for the requested byte (0 = command, 1 = data).
  - data0 / data1  in  8  byte to write.
  - gnt0 / gnt1  out  1  one-cycle accept pulse; the byte is latched in this cycle.
  - done  out  1  one-cycle pulse on the last cycle of the post-byte wait.
  - busy  out  1  high whenever the FSM is not in IDLE.
  - SF_D  out  4  LCD data nibble.
  - LCD_E  out  1  LCD enable strobe.
  - LCD_RS  out  1  LCD register select.
  - LCD_RW  out  1  LCD read/write; tied to 0 (write only).

Function
REQ-007 SHALL implement FSM states IDLE, HI_SETUP, HI_EN, HI_HOLD, GAP, LO_SETUP, LO_EN, LO_HOLD and WAIT, advanced by a single down-counter of at least 17 bits.
REQ-008 SHALL sample requests only in IDLE.
  - A request present in IDLE produces exactly one gnt pulse in that cycle.
  - In that same cycle the rs/data of the granted requester are latched and the FSM enters HI_SETUP.
REQ-009 SHALL arbitrate round-robin when req0 and req1 are both high in IDLE.
  - The priority pointer starts at requester 0 after reset.
  - After each grant, the pointer moves to the other requester.
  - A lone request is granted regardless of the pointer.
REQ-010 SHALL never assert gnt0 and gnt1 in the same cycle, and SHALL assert no gnt outside IDLE.
REQ-011 SHALL require each requester to hold req, rs and data stable until its gnt; a req held high after gnt is treated as a new request at the next IDLE.
REQ-012 SHALL hold each state for these durations, gnt at cycle t:
  - HI_SETUP: T_SETUP cycles (t+1..t+2 with defaults).
  - HI_EN: T_EN cycles (t+3..t+14).
  - HI_HOLD: 1 cycle (t+15).
  - GAP: T_GAP cycles (t+16..t+65).
  - LO_SETUP: T_SETUP cycles (t+66..t+67).
  - LO_EN: T_EN cycles (t+68..t+79).
  - LO_HOLD: 1 cycle (t+80).
  - WAIT: T_WAIT or T_CLR_WAIT cycles (t+81..t+2080).
REQ-013 SHALL drive SF_D from the latched byte:
  - latched byte[7:4] in HI_SETUP, HI_EN and HI_HOLD;
  - latched byte[3:0] in LO_SETUP, LO_EN and LO_HOLD;
  - 4'h0 in all other states, so the output can be OR-combined on a shared bus.
REQ-014 SHALL drive LCD_E high only in HI_EN and LO_EN.
REQ-015 SHALL drive LCD_RS with the latched rs from HI_SETUP through LO_HOLD, and 0 otherwise.
REQ-016 SHALL use T_CLR_WAIT in WAIT when the latched byte is 8'h01 with rs=0, and T_WAIT otherwise.
REQ-017 SHALL pulse done on the final WAIT cycle and enter IDLE on the next cycle.
  - Earliest next gnt with defaults: t+2081.
  - gnt-to-done latency with defaults: 2080 cycles (82080 for clear).
REQ-018 SHALL hold busy high from the cycle after gnt through the cycle done is high.
REQ-019 SHALL produce exactly one done pulse per gnt, in grant order.

Reset
REQ-020 SHALL, while reset=0, asynchronously set:
  - FSM to IDLE, counter to 0, priority pointer to requester 0;
  - gnt0, gnt1, done, busy, LCD_E, LCD_RS, LCD_RW to 0, and SF_D to 4'h0.
REQ-021 SHALL, on reset asserted mid-transfer, abandon the latched byte with no done pulse and no further LCD_E edges.
REQ-022 SHALL accept a request in the first clock edge after reset deasserts.

Verification
REQ-023 Single write: req0=1, rs0=1, data0=8'h48 -> gnt0 at t, then:
  - SF_D=4'h4 with RS=1 while LCD_E is high on cycles t+3..t+14;
  - SF_D=4'h8 while LCD_E is high on cycles t+68..t+79;
  - done at t+2080, busy low at t+2081.
REQ-024 Clear command: req1=1, rs1=0, data1=8'h01 -> done at t+82080, and LCD_E high for exactly 24 cycles in total.
REQ-025 Contention: req0 and req1 held high from reset release -> grant order 0,1,0,1, grants spaced 2081 cycles apart, and never a simultaneous gnt.
REQ-026 Busy blocking: req1 raised at t+500 during a requester-0 transfer -> gnt1 at t+2081, with no gnt during busy.
REQ-027 Reset abort: reset=0 at t+70 (within LO_EN) -> LCD_E, SF_D, RS and busy go to 0 in the same cycle, and no done follows.
REQ-028 Idle outputs: no requests for 5000 cycles -> SF_D=0, LCD_E=0, LCD_RW=0 and busy=0 throughout.
